// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB digit first.
// Optional `ADDSUB_SATURATE_EN clamps the result on signed overflow instead of wrapping.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       o_dbg_state
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("addsub_serial: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [DIGIT:0]     w_dsum;
    logic [WIDTH-1:0]   w_s_next;
    logic [WIDTH-1:0]   w_s_final;
    logic               w_ovf_next;
    logic               w_last;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and the result holds until taken.
    always_comb begin
        w_dsum     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
        // New digit enters at the top; after NDIG digits the LSB digit sits at the bottom.
        w_s_next   = WIDTH'({w_dsum[DIGIT-1:0], r_s} >> DIGIT);
        w_ovf_next = (r_a_msb == r_b_msb) && (w_s_next[WIDTH-1] != r_a_msb);
        w_last     = (r_cnt == CNT_W'(NDIG - 1));
`ifdef ADDSUB_SATURATE_EN
        if (w_ovf_next) begin
            w_s_final = r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_s_final = w_s_next;
        end
`else
        w_s_final  = w_s_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b ^ {WIDTH{sub}};
                        r_a_msb    <= a[WIDTH-1];
                        r_b_msb    <= b[WIDTH-1] ^ sub;
                        r_carry    <= sub;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_dsum[DIGIT];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_s         <= w_s_final;
                        r_cout      <= w_dsum[DIGIT];
                        r_ovf       <= w_ovf_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_s <= w_s_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign s           = r_s;
    assign cout        = r_cout;
    assign ovf         = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: a DIGIT=4 instance and a DIGIT=16 instance checked against an
// integer-arithmetic reference model; honours `ADDSUB_SATURATE_EN like the design.
module tb_addsub_serial;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [1:0]   in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a [2];
    logic [W-1:0] b [2];
    logic [W-1:0] s [2];
    logic [1:0]   dbg0, dbg1;

    int vectors     = 0;
    int miscompares = 0;

    addsub_serial #(.WIDTH(W), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .sub(sub[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .s(s[0]), .cout(cout[0]), .ovf(ovf[0]), .o_dbg_state(dbg0)
    );

    addsub_serial #(.WIDTH(W), .DIGIT(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .sub(sub[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .s(s[1]), .cout(cout[1]), .ovf(ovf[1]), .o_dbg_state(dbg1)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the whole words.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                                  output logic [W-1:0] es, output logic ec, output logic eo);
        int sa, sb, r;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        r  = sv ? (sa - sb) : (sa + sb);
        eo = (r > 32767) || (r < -32768);
        es = sv ? (av - bv) : (av + bv);
        ec = sv ? (av >= bv) : ((32'(av) + 32'(bv)) > 32'h0000_FFFF);
`ifdef ADDSUB_SATURATE_EN
        if (eo) es = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    task automatic issue(input int u, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input int exp_lat, input int hold, input bit pulse);
        logic [W-1:0] es;
        logic         ec, eo;
        int           n;
        model(av, bv, sv, es, ec, eo);
        @(negedge clk);
        a[u] = av; b[u] = bv; sub[u] = sv; in_valid[u] = 1'b1; out_ready[u] = 1'b0;
        check("in_ready_idle", in_ready[u], 1'b1);
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        a[u] = W'($urandom); b[u] = W'($urandom); sub[u] = 1'($urandom);
        n = 0;
        while (!out_valid[u] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", W'(n), W'(exp_lat));
        check("s", s[u], es);
        check("cout", cout[u], ec);
        check("ovf", ovf[u], eo);
        check("in_ready_busy", in_ready[u], 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid[u] = pulse ? 1'b1 : 1'($urandom_range(0, 1));
            a[u] = W'($urandom); b[u] = W'($urandom); sub[u] = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", out_valid[u], 1'b1);
            check("hold_s", s[u], es);
            check("hold_cout", cout[u], ec);
            check("hold_ovf", ovf[u], eo);
            check("hold_in_ready", in_ready[u], 1'b0);
        end
        @(negedge clk);
        in_valid[u] = 1'b0; out_ready[u] = 1'b1;
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
        check("post_out_valid", out_valid[u], 1'b0);
        check("post_in_ready", in_ready[u], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        in_valid = '0; out_ready = '0; sub = '0;
        for (int u = 0; u < 2; u++) begin
            a[u] = '0; b[u] = '0;
        end
        #12;
        for (int u = 0; u < 2; u++) begin
            check("rst_s", s[u], 16'h0000);
            check("rst_cout", cout[u], 1'b0);
            check("rst_ovf", ovf[u], 1'b0);
            check("rst_out_valid", out_valid[u], 1'b0);
            check("rst_in_ready", in_ready[u], 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        issue(0, 16'h1234, 16'h0FFF, 1'b0, 4, 0, 1'b0);
        issue(0, 16'h0005, 16'h0007, 1'b1, 4, 1, 1'b0);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 4, 0, 1'b0);
        issue(0, 16'h8000, 16'h0001, 1'b1, 4, 2, 1'b0);
        issue(0, 16'h0000, 16'h8000, 1'b1, 4, 0, 1'b0);
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 4, 0, 1'b0);
        issue(0, 16'h8000, 16'h8000, 1'b0, 4, 0, 1'b0);
        // Long stall in DONE with new operands offered every cycle
        issue(0, 16'hABCD, 16'h1357, 1'b1, 4, 5, 1'b1);

        // Reset in the second RUN cycle
        @(negedge clk);
        a[0] = 16'h1234; b[0] = 16'h0FFF; sub[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrun_out_valid", out_valid[0], 1'b0);
        check("midrun_s", s[0], 16'h0000);
        check("midrun_in_ready", in_ready[0], 1'b1);
        check("midrun_cout", cout[0], 1'b0);
        check("midrun_ovf", ovf[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 16'h0001, 16'h0001, 1'b0, 4, 0, 1'b0);

        // Single-digit instance
        issue(1, 16'h1234, 16'h0FFF, 1'b0, 1, 0, 1'b0);
        issue(1, 16'h7FFF, 16'h0001, 1'b0, 1, 1, 1'b0);
        issue(1, 16'h8000, 16'h0001, 1'b1, 1, 0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            ra = W'($urandom); rb = W'($urandom);
            issue(1, ra, rb, 1'($urandom), 1, $urandom_range(0, 2), 1'b0);
        end

        // Randomized operands, with biased corner values mixed in
        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom); rb = W'($urandom);
            if ($urandom_range(0, 4) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            if ($urandom_range(0, 4) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
            issue(0, ra, rb, 1'($urandom), 4, $urandom_range(0, 3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
